// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared byte UART transmitter: four message sources,
// whole-message ownership, start/busy handshake with timeout, idle gap between messages.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES    = 20000000,
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  input  logic [3:0]  last,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        idle
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TO_MAX   = TW'(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_DONE, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    ack_q, ack_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          is_last_q, is_last_d;
  logic [1:0]    owner_q, owner_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    pick;

  // First requester strictly after the previous owner, wrapping; the previous owner is tried last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick = rr_pick(req, owner_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = 4'b0000;
    start_d   = 1'b0;
    data_d    = data_q;
    is_last_d = is_last_q;
    owner_d   = owner_q;
    gap_d     = gap_q;
    to_d      = to_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = pick;
          grant_d = 4'b0001 << pick;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (req[owner_q]) begin
          data_d    = data_in[{owner_q, 3'b000} +: 8];
          start_d   = 1'b1;
          ack_d     = 4'b0001 << owner_q;
          is_last_d = last[owner_q];
          to_d      = '0;
          state_d   = S_WAIT_HI;
        end else begin
          grant_d = 4'b0000;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      S_WAIT_HI: begin
        // A transmitter that never reports busy is given up on after START_TIMEOUT clocks.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          if (to_q != TO_MAX) to_d = to_q + 1'b1;
          if (int'(to_q) + 1 >= START_TIMEOUT) state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (is_last_q) begin
            grant_d = 4'b0000;
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      ack_q     <= 4'b0000;
      start_q   <= 1'b0;
      data_q    <= 8'h00;
      is_last_q <= 1'b0;
      owner_q   <= 2'd3;
      gap_q     <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      data_q    <= data_d;
      is_last_q <= is_last_d;
      owner_q   <= owner_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign idle     = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: source queues, a busy-for-10-cycles transmitter
// model and a scoreboard of expected (source, byte) starts.
module tb_uart_tx_arbiter;

  localparam int GAP = 5;
  localparam int TOUT = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        idle;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .last(last),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy for 10 clocks after each start, unless disabled.
  logic tx_mode = 1'b1;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start === 1'b1 && tx_mode) busy_cnt <= 10;
    else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q[4][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstart = 0;
  int prev_start = 0;
  bit have_prev = 0;
  bit chk_to = 0;
  int zrun = 0;
  bit zvalid = 0;
  logic [3:0] prev_grant = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic drive_src();
    logic [8:0] b;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() != 0) begin
        b = src_q[i][0];
        req[i] = 1'b1;
        data_in[i*8 +: 8] = b[7:0];
        last[i] = b[8];
      end else begin
        req[i] = 1'b0;
        data_in[i*8 +: 8] = 8'h00;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic push_msg(input int s, input logic [8:0] b);
    src_q[s].push_back(b);
  endtask

  task automatic push_exp(input int s, input logic [7:0] d);
    exp_t e;
    e.src = 2'(s);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start === 1'b1) begin
      check("start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("ack_with_start", 32'(ack), 32'(4'b0001 << e.src));
        check("grant_owner", 32'(grant), 32'(4'b0001 << e.src));
      end
      if (chk_to && have_prev) check("timeout_interval", 32'(cyc - prev_start), 32'(TOUT + 2));
      have_prev = 1;
      prev_start = cyc;
      nstart++;
    end else begin
      check("ack_without_start", 32'(ack), 32'd0);
    end
    if (grant == 4'b0000) begin
      if (prev_grant != 4'b0000) begin
        zrun = 1;
        zvalid = 1;
      end else begin
        zrun++;
      end
    end else if (prev_grant == 4'b0000 && zvalid) begin
      check("gap_len", 32'(zrun), 32'(GAP + 1));
      zvalid = 0;
    end
    prev_grant = grant;
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1 && src_q[i].size() != 0) src_q[i].delete(0);
    end
    drive_src();
  endtask

  task automatic new_test();
    zvalid = 0;
    have_prev = 0;
  endtask

  task automatic run_until_done(input string tag, input int budget, input int settle);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (settle) step();
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n0;
    int n;
    n0 = nstart;
    n = 0;
    while (nstart == n0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, 32'(nstart != n0), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = 4'b0000;
    data_in = 32'h0;
    last = 4'b0000;
    drive_src();
    step();
    step();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;

    // No requests: stays idle.
    repeat (100) step();
    check("quiet_idle", 32'(idle), 32'd1);
    check("quiet_grant", 32'(grant), 32'd0);
    check("quiet_starts", 32'(nstart), 32'd0);

    // Sources 0, 1, 3 with two single-byte messages each: two rounds of 0, 1, 3.
    new_test();
    push_msg(0, {1'b1, 8'h10}); push_msg(0, {1'b1, 8'h11});
    push_msg(1, {1'b1, 8'h20}); push_msg(1, {1'b1, 8'h21});
    push_msg(3, {1'b1, 8'h30}); push_msg(3, {1'b1, 8'h31});
    push_exp(0, 8'h10); push_exp(1, 8'h20); push_exp(3, 8'h30);
    push_exp(0, 8'h11); push_exp(1, 8'h21); push_exp(3, 8'h31);
    drive_src();
    run_until_done("rr", 400, GAP + 4);

    // Source 2 sends a 3-byte message; source 0 joins mid-message and must wait.
    new_test();
    push_msg(2, {1'b0, 8'h41}); push_msg(2, {1'b0, 8'h42}); push_msg(2, {1'b1, 8'h43});
    push_exp(2, 8'h41); push_exp(2, 8'h42); push_exp(2, 8'h43);
    drive_src();
    wait_start("msg2", 20);
    push_msg(0, {1'b1, 8'h50});
    push_exp(0, 8'h50);
    drive_src();
    run_until_done("msg2", 300, GAP + 4);

    // Sources 1 and 0 request together after source 0 owned last: 1 wins the whole message.
    new_test();
    push_msg(1, {1'b0, 8'ha1}); push_msg(1, {1'b0, 8'ha2}); push_msg(1, {1'b1, 8'ha3});
    push_msg(0, {1'b1, 8'hb0});
    push_exp(1, 8'ha1); push_exp(1, 8'ha2); push_exp(1, 8'ha3); push_exp(0, 8'hb0);
    drive_src();
    run_until_done("mid", 300, GAP + 4);

    // Transmitter never goes busy: each byte proceeds after the start timeout.
    new_test();
    tx_mode = 1'b0;
    chk_to = 1;
    push_msg(3, {1'b0, 8'h81}); push_msg(3, {1'b1, 8'h82});
    push_exp(3, 8'h81); push_exp(3, 8'h82);
    drive_src();
    run_until_done("tout", 200, TOUT + GAP + 6);
    check("tout_idle", 32'(idle), 32'd1);
    chk_to = 0;
    tx_mode = 1'b1;

    // Reset while waiting for the frame to finish.
    new_test();
    push_msg(1, {1'b0, 8'h61}); push_msg(1, {1'b1, 8'h62});
    push_exp(1, 8'h61);
    drive_src();
    wait_start("rstmid", 20);
    n = 0;
    while (!tx_busy && n < 20) begin
      step();
      n++;
    end
    check("rstmid_busy", 32'(tx_busy), 32'd1);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    drive_src();
    step();
    rst = 1'b0;
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_grant", 32'(grant), 32'd0);
    check("rstmid_start", 32'(tx_start), 32'd0);
    check("rstmid_data", 32'(tx_data), 32'h00);
    check("rstmid_idle", 32'(idle), 32'd1);
    repeat (12) step();
    new_test();
    push_msg(0, {1'b1, 8'h71}); push_msg(2, {1'b1, 8'h72});
    push_exp(0, 8'h71); push_exp(2, 8'h72);
    drive_src();
    run_until_done("after_rst", 200, GAP + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
